// File: rtl/regfile_gen2.sv
// Parametrised integer register file with a sequential clear engine and an optional hard-wired zero entry.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_gen2 #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic              WE3,
  input  logic [XLEN-1:0]   WD3,
  input  logic              clr_req,
  output logic [XLEN-1:0]   RD1,
  output logic [XLEN-1:0]   RD2,
  output logic              busy,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              wr_drop_q, wr_drop_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic wr_zero;
  logic fwd_ok;

  assign wr_zero = (ZERO_REG != 0) && (A3 == '0);

`ifdef REGFILE_BYPASS_EN
  assign fwd_ok = (state_q == ST_READY) && WE3;
`else
  assign fwd_ok = 1'b0;
`endif

  // Next state, clear sweep and array write port selection
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = A3;
    mem_wdata = WD3;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        wr_drop_d = WE3;
        if (clr_req) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
          if (ptr_q == PTR_LAST) begin
            state_d = ST_READY;
          end
        end
      end
      default: begin
        if (clr_req) begin
          state_d   = ST_INIT;
          ptr_d     = '0;
          wr_drop_d = WE3;
        end else if (WE3 && !wr_zero) begin
          mem_we = 1'b1;
        end
      end
    endcase
    busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      ptr_q     <= '0;
      busy_q    <= 1'b1;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage has no reset; the sweep zeroes it
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read priority: zero entry, INIT gating, forwarding, array
  function automatic logic [XLEN-1:0] rd_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [XLEN-1:0]   arr,
    input logic              gated,
    input logic              fwd,
    input logic [ADDR_W-1:0] waddr,
    input logic [XLEN-1:0]   wdata
  );
    if ((ZERO_REG != 0) && (addr == '0)) return '0;
    if (gated) return '0;
    if (fwd && (addr == waddr)) return wdata;
    return arr;
  endfunction

  assign RD1 = rd_sel(A1, mem_q[A1], state_q == ST_INIT, fwd_ok, A3, WD3);
  assign RD2 = rd_sel(A2, mem_q[A2], state_q == ST_INIT, fwd_ok, A3, WD3);

  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_gen2.sv
// Directed bench for regfile_gen2: a default instance plus one with ZERO_REG=0 sharing the same stimulus.
module tb_regfile_gen2;

  logic        CLK;
  logic        reset_n;
  logic [4:0]  A1, A2, A3;
  logic        WE3;
  logic [31:0] WD3;
  logic        clr_req;
  logic [31:0] RD1, RD2, RD1_nz, RD2_nz;
  logic        busy, wr_drop, busy_nz, wr_drop_nz;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_gen2 u_dut (
    .CLK(CLK), .reset_n(reset_n), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
    .clr_req(clr_req), .RD1(RD1), .RD2(RD2), .busy(busy), .wr_drop(wr_drop)
  );

  regfile_gen2 #(.ZERO_REG(0)) u_dut_nz (
    .CLK(CLK), .reset_n(reset_n), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
    .clr_req(clr_req), .RD1(RD1_nz), .RD2(RD2_nz), .busy(busy_nz), .wr_drop(wr_drop_nz)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] nz1;
    logic [31:0] nz2;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2);
    WE3 = we; A3 = a3; WD3 = wd; A1 = a1; A2 = a2;
  endtask

  // Counts rising edges until busy drops, tallying any non-zero read while busy
  task automatic wait_sweep(output int cnt, output int rd_bad);
    cnt = 0;
    rd_bad = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
      if (busy && (RD1 !== 32'h0 || RD2 !== 32'h0 || RD1_nz !== 32'h0 || RD2_nz !== 32'h0))
        rd_bad++;
    end
  endtask

  initial begin
    int cnt;
    int bad;
    logic [31:0] exp_v;

    vt[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0,        32'h0,        32'h0};
    vt[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[2] = '{1'b1, 5'd0,  32'h12345678, 5'd7,  5'd1,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    vt[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
    vt[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd0,  5'd5,  32'h0,        32'h0,        32'h12345678, 32'h0};
    vt[5] = '{1'b1, 5'd1,  32'h11111111, 5'd31, 5'd7,  32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF};
    vt[6] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h11111111, 32'hCAFEF00D, 32'h11111111, 32'hCAFEF00D};
    vt[7] = '{1'b1, 5'd7,  32'h77777777, 5'd1,  5'd0,  32'h11111111, 32'h0,        32'h11111111, 32'h12345678};
    vt[8] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h77777777, 32'h77777777, 32'h77777777, 32'h77777777};

    reset_n = 1'b0;
    clr_req = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd9);

    // Reset sweep
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_wr_drop", 32'(wr_drop), 32'h0);
    chk("rst_rd1", RD1, 32'h0);
    chk("rst_rd2", RD2, 32'h0);
    reset_n = 1'b1;
    wait_sweep(cnt, bad);
    chk("sweep_len", 32'(cnt), 32'd32);
    chk("sweep_rd_gated", 32'(bad), 32'h0);
    chk("sweep_busy_nz", 32'(busy_nz), 32'h0);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      A2 = 5'(31 - i);
      #1;
      if (RD1 !== 32'h0 || RD2 !== 32'h0 || RD1_nz !== 32'h0 || RD2_nz !== 32'h0) bad++;
    end
    chk("all_zero_after_sweep", 32'(bad), 32'h0);

    // Table-driven write/read vectors
    for (int i = 0; i < 9; i++) begin
      set_in(vt[i].we, vt[i].a3, vt[i].wd, vt[i].a1, vt[i].a2);
      #1;
      chk($sformatf("vec%0d_rd1", i), RD1, vt[i].rd1);
      chk($sformatf("vec%0d_rd2", i), RD2, vt[i].rd2);
      chk($sformatf("vec%0d_nz_rd1", i), RD1_nz, vt[i].nz1);
      chk($sformatf("vec%0d_nz_rd2", i), RD2_nz, vt[i].nz2);
      tick();
      chk($sformatf("vec%0d_wr_drop", i), 32'(wr_drop), 32'h0);
      chk($sformatf("vec%0d_nz_wr_drop", i), 32'(wr_drop_nz), 32'h0);
    end
    WE3 = 1'b0;

    // Same-cycle forwarding
    set_in(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'hA5A5A5A5;
`else
    exp_v = 32'h0;
`endif
    chk("bp_rd1_pre", RD1, exp_v);
    chk("bp_rd2_pre", RD2, exp_v);
    tick();
    WE3 = 1'b0;
    #1;
    chk("bp_rd1_post", RD1, 32'hA5A5A5A5);

    set_in(1'b1, 5'd0, 32'hBEEF0000, 5'd0, 5'd9);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'hBEEF0000;
`else
    exp_v = 32'h12345678;
`endif
    chk("bp_zero_no_fwd", RD1, 32'h0);
    chk("bp_nz_entry0_pre", RD1_nz, exp_v);
    tick();
    WE3 = 1'b0;
    #1;
    chk("bp_nz_entry0_post", RD1_nz, 32'hBEEF0000);
    chk("zero_write_no_drop", 32'(wr_drop), 32'h0);

    // Clear request colliding with a write, then a write during INIT
    set_in(1'b1, 5'd3, 32'h33333333, 5'd3, 5'd9);
    tick();
    WE3 = 1'b0;
    #1;
    chk("pre_clr_rd1", RD1, 32'h33333333);
    clr_req = 1'b1;
    set_in(1'b1, 5'd3, 32'h1, 5'd3, 5'd9);
    tick();
    clr_req = 1'b0;
    chk("clr_wr_drop", 32'(wr_drop), 32'h1);
    chk("clr_busy", 32'(busy), 32'h1);
    chk("clr_rd1_gated", RD1, 32'h0);
    set_in(1'b1, 5'd4, 32'h44, 5'd3, 5'd9);
    tick();
    WE3 = 1'b0;
    chk("init_wr_drop", 32'(wr_drop), 32'h1);
    wait_sweep(cnt, bad);
    chk("clr_sweep_len", 32'(cnt + 1), 32'd32);
    chk("clr_sweep_rd_gated", 32'(bad), 32'h0);
    chk("clr_wr_drop_idle", 32'(wr_drop), 32'h0);
    chk("clr_rd1_entry3", RD1, 32'h0);
    chk("clr_rd2_entry9", RD2, 32'h0);
    A1 = 5'd0;
    A2 = 5'd4;
    #1;
    chk("clr_nz_entry0", RD1_nz, 32'h0);
    chk("clr_entry4", RD2, 32'h0);

    // Reset asserted part-way through a sweep
    set_in(1'b1, 5'd31, 32'hCAFE0031, 5'd31, 5'd5);
    tick();
    WE3 = 1'b0;
    #1;
    chk("pre_midrst_rd1", RD1, 32'hCAFE0031);
    reset_n = 1'b0;
    #1;
    chk("rst2_busy", 32'(busy), 32'h1);
    chk("rst2_rd1_gated", RD1, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h1);
    chk("midrst_rd1", RD1, 32'h0);
    chk("midrst_wr_drop", 32'(wr_drop), 32'h0);
    tick();
    reset_n = 1'b1;
    wait_sweep(cnt, bad);
    chk("midrst_sweep_len", 32'(cnt), 32'd32);
    chk("midrst_rd_gated", 32'(bad), 32'h0);
    chk("midrst_entry31_cleared", RD1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
